// File: rtl/truth_table_equiv_checker.sv
// truth_table_equiv_checker
//   Sequential exhaustive equivalence checker for N_FUNC pairs of N_IN-input
//   Boolean functions given as truth tables. One input vector is examined per
//   cycle; all pairs are compared in parallel.
//
//   Optional feature macro: EQCHK_STOP_ON_FIRST_EN
//     defined   -> the sweep ends on the edge that records the first mismatch
//     undefined -> every input vector is always swept
//
//   Ports
//     clk           rising-edge clock
//     rst           synchronous active-high reset
//     start         one-cycle request, accepted in IDLE/DONE only
//     abort         cancels a running sweep (wins over start)
//     tt_a, tt_b    packed truth tables; function f, vector v at bit f*2^N_IN+v
//     busy          high while sweeping
//     done          level, high in DONE
//     equal         valid with done; 1 when every pair matched everywhere
//     mismatch_mask bit f set when pair f differed on any vector
//     first_valid   at least one mismatch recorded
//     first_vec     lowest-numbered vector with any mismatch
//     mism_count    number of vectors with at least one differing pair
`timescale 1ns/1ps

module truth_table_equiv_checker #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned N_FUNC = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic [N_FUNC*(1<<N_IN)-1:0]    tt_a,
  input  logic [N_FUNC*(1<<N_IN)-1:0]    tt_b,
  output logic                           busy,
  output logic                           done,
  output logic                           equal,
  output logic [N_FUNC-1:0]              mismatch_mask,
  output logic                           first_valid,
  output logic [N_IN-1:0]                first_vec,
  output logic [N_IN:0]                  mism_count
);

  localparam int unsigned DEPTH = 1 << N_IN;
  localparam int unsigned TT_W  = N_FUNC * DEPTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [TT_W-1:0]     tt_a_q;
  logic [TT_W-1:0]     tt_b_q;
  logic [N_IN-1:0]     vec_q;
  logic                busy_q;
  logic                done_q;
  logic                equal_q;
  logic [N_FUNC-1:0]   mask_q;
  logic                first_valid_q;
  logic [N_IN-1:0]     first_vec_q;
  logic [N_IN:0]       count_q;

  logic [N_FUNC-1:0]   diff;
  logic                any_diff;
  logic                last_vec;
  logic                leave_sweep;
  logic [N_FUNC-1:0]   mask_d;
  logic [N_IN:0]       count_d;

  // Per-pair table slices use constant part-selects so the vector index
  // exactly matches the table depth.
  for (genvar g = 0; g < N_FUNC; g++) begin : g_pair
    logic [DEPTH-1:0] row_a;
    logic [DEPTH-1:0] row_b;
    assign row_a   = tt_a_q[g*DEPTH +: DEPTH];
    assign row_b   = tt_b_q[g*DEPTH +: DEPTH];
    assign diff[g] = row_a[vec_q] ^ row_b[vec_q];
  end

  always_comb begin
    any_diff = |diff;
    last_vec = (vec_q == '1);
    mask_d   = mask_q | diff;
    count_d  = any_diff ? count_q + (N_IN+1)'(1) : count_q;
`ifdef EQCHK_STOP_ON_FIRST_EN
    leave_sweep = last_vec || any_diff;
`else
    leave_sweep = last_vec;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      tt_a_q        <= '0;
      tt_b_q        <= '0;
      vec_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      equal_q       <= 1'b0;
      mask_q        <= '0;
      first_valid_q <= 1'b0;
      first_vec_q   <= '0;
      count_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          // abort has no effect here except to veto a simultaneous start
          if (start && !abort) begin
            state_q       <= S_SWEEP;
            tt_a_q        <= tt_a;
            tt_b_q        <= tt_b;
            vec_q         <= '0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            equal_q       <= 1'b0;
            mask_q        <= '0;
            first_valid_q <= 1'b0;
            first_vec_q   <= '0;
            count_q       <= '0;
          end
        end
        S_SWEEP: begin
          if (abort) begin
            state_q       <= S_IDLE;
            vec_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            equal_q       <= 1'b0;
            mask_q        <= '0;
            first_valid_q <= 1'b0;
            first_vec_q   <= '0;
            count_q       <= '0;
          end else begin
            mask_q  <= mask_d;
            count_q <= count_d;
            if (any_diff && !first_valid_q) begin
              first_vec_q   <= vec_q;
              first_valid_q <= 1'b1;
            end
            // wraps to 0 after the last vector
            vec_q <= vec_q + N_IN'(1);
            if (leave_sweep) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              equal_q <= (mask_d == '0);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign equal         = equal_q;
  assign mismatch_mask = mask_q;
  assign first_valid   = first_valid_q;
  assign first_vec     = first_vec_q;
  assign mism_count    = count_q;

endmodule

// File: tb/tb_truth_table_equiv_checker.sv
// Self-checking bench for truth_table_equiv_checker (N_IN=4, N_FUNC=3).
`timescale 1ns/1ps

module tb_truth_table_equiv_checker;

  localparam int N_IN   = 4;
  localparam int N_FUNC = 3;
  localparam int DEPTH  = 16;
  localparam int TT_W   = 48;
`ifdef EQCHK_STOP_ON_FIRST_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  typedef struct {
    logic [N_FUNC-1:0] mask;
    logic              fv;
    logic [N_IN-1:0]   first;
    logic [N_IN:0]     cnt;
    logic              eq;
    int                cycles;
    int                busy_cycles;
    logic              done;
  } res_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [TT_W-1:0]   tt_a = '0;
  logic [TT_W-1:0]   tt_b = '0;
  logic              busy, done, equal, first_valid;
  logic [N_FUNC-1:0] mismatch_mask;
  logic [N_IN-1:0]   first_vec;
  logic [N_IN:0]     mism_count;

  int errors = 0;
  int checks = 0;

  truth_table_equiv_checker #(.N_IN(N_IN), .N_FUNC(N_FUNC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .tt_a(tt_a), .tt_b(tt_b),
    .busy(busy), .done(done), .equal(equal),
    .mismatch_mask(mismatch_mask), .first_valid(first_valid),
    .first_vec(first_vec), .mism_count(mism_count)
  );

  always #5 clk = ~clk;

  function automatic logic [TT_W-1:0] rnd48();
    return TT_W'({$urandom, $urandom});
  endfunction

  // Reference: examine every vector of every pair straight from the tables.
  function automatic res_t model(input logic [TT_W-1:0] a, input logic [TT_W-1:0] b);
    res_t r;
    logic [TT_W-1:0] d, t;
    bit any;
    r.mask = '0; r.fv = 1'b0; r.first = '0; r.cnt = '0;
    r.busy_cycles = 0; r.done = 1'b1;
    d = a ^ b;
    for (int v = 0; v < DEPTH; v++) begin
      if (STOP && r.fv) break;
      any = 1'b0;
      for (int f = 0; f < N_FUNC; f++) begin
        t = d >> (f*DEPTH + v);
        if (t[0]) begin
          r.mask = r.mask | N_FUNC'(1 << f);
          any = 1'b1;
        end
      end
      if (any) begin
        r.cnt = r.cnt + 5'd1;
        if (!r.fv) begin
          r.fv = 1'b1;
          r.first = N_IN'(v);
        end
      end
    end
    r.eq = (r.mask == '0);
    r.cycles = (STOP && r.fv) ? int'(r.first) + 1 : DEPTH;
    r.busy_cycles = r.cycles;
    return r;
  endfunction

  // Stimulus only: start a sweep, scramble inputs after the latch, and wait
  // (bounded) for done while counting busy cycles.
  task automatic do_sweep(input logic [TT_W-1:0] a, input logic [TT_W-1:0] b, output res_t o);
    int n;
    int bc;
    @(negedge clk);
    tt_a = a; tt_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tt_a = rnd48(); tt_b = rnd48();
    n = 0; bc = 0;
    while (!done && n < 100) begin
      if (busy) bc++;
      @(posedge clk); #1;
      n++;
    end
    o.cycles = n; o.busy_cycles = bc;
    o.mask = mismatch_mask; o.fv = first_valid; o.first = first_vec;
    o.cnt = mism_count; o.eq = equal; o.done = done;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; tt_a = rnd48(); tt_b = rnd48();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, equal, mismatch_mask, first_valid, first_vec, mism_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b eq=%b mask=%b fv=%b first=%0d cnt=%0d, need all zero",
               busy, done, equal, mismatch_mask, first_valid, first_vec, mism_count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sweep_patterns();
    logic [TT_W-1:0] pa [10];
    logic [TT_W-1:0] pb [10];
    logic [TT_W-1:0] base;
    res_t e, o;
    base = 48'h0F0F_A5A5_3C3C;
    pa[0] = base; pb[0] = base;
    pa[1] = base; pb[1] = base ^ (48'd1 << 22);
    pa[2] = base; pb[2] = base ^ (48'd1 << 41) ^ (48'd1 << 3);
    pa[3] = base; pb[3] = ~base;
    for (int i = 4; i < 10; i++) begin
      pa[i] = rnd48();
      case (i % 3)
        0:       pb[i] = pa[i];
        1:       pb[i] = pa[i] ^ (rnd48() & rnd48() & rnd48());
        default: pb[i] = rnd48();
      endcase
    end
    for (int i = 0; i < 10; i++) begin
      e = model(pa[i], pb[i]);
      do_sweep(pa[i], pb[i], o);
      checks++;
      if (o.cycles !== e.cycles) begin
        errors++;
        $display("FAIL sweep_latency[%0d]: got %0d cycles, need %0d", i, o.cycles, e.cycles);
      end
      checks++;
      if (o.busy_cycles !== e.busy_cycles || busy !== 1'b0) begin
        errors++;
        $display("FAIL sweep_busy[%0d]: got %0d busy cycles (busy now %b), need %0d then 0",
                 i, o.busy_cycles, busy, e.busy_cycles);
      end
      checks++;
      if (o.done !== 1'b1 || o.eq !== e.eq) begin
        errors++;
        $display("FAIL sweep_done_equal[%0d]: got done=%b equal=%b, need 1/%b", i, o.done, o.eq, e.eq);
      end
      checks++;
      if (o.mask !== e.mask) begin
        errors++;
        $display("FAIL sweep_mask[%0d]: got %b, need %b", i, o.mask, e.mask);
      end
      checks++;
      if (o.fv !== e.fv || o.first !== e.first) begin
        errors++;
        $display("FAIL sweep_first[%0d]: got fv=%b vec=%0d, need fv=%b vec=%0d", i, o.fv, o.first, e.fv, e.first);
      end
      checks++;
      if (o.cnt !== e.cnt) begin
        errors++;
        $display("FAIL sweep_count[%0d]: got %0d, need %0d", i, o.cnt, e.cnt);
      end
    end
  endtask

  task automatic test_hold();
    res_t e, o;
    logic [TT_W-1:0] a, b;
    a = rnd48(); b = a ^ (rnd48() & rnd48());
    e = model(a, b);
    do_sweep(a, b, o);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || mismatch_mask !== e.mask || mism_count !== e.cnt ||
        first_vec !== e.first || first_valid !== e.fv || equal !== e.eq) begin
      errors++;
      $display("FAIL done_hold: got done=%b busy=%b mask=%b cnt=%0d first=%0d fv=%b eq=%b, need 1 0 %b %0d %0d %b %b",
               done, busy, mismatch_mask, mism_count, first_vec, first_valid, equal,
               e.mask, e.cnt, e.first, e.fv, e.eq);
    end
  endtask

  task automatic test_abort();
    logic [TT_W-1:0] a, b;
    logic [N_FUNC-1:0] exp_mask;
    logic [N_IN:0] exp_cnt;
    int done_seen;
    res_t e, o;
    a = 48'h0F0F_A5A5_3C3C;
    b = a ^ (48'd1 << (STOP ? 12 : 2));
    exp_mask = STOP ? 3'b000 : 3'b001;
    exp_cnt  = STOP ? 5'd0 : 5'd1;
    @(negedge clk);
    tt_a = a; tt_b = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; tt_a = rnd48(); tt_b = rnd48();
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || mismatch_mask !== exp_mask || mism_count !== exp_cnt) begin
      errors++;
      $display("FAIL start_while_busy: got busy=%b done=%b mask=%b cnt=%0d, need 1 0 %b %0d",
               busy, done, mismatch_mask, mism_count, exp_mask, exp_cnt);
    end
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if ({busy, done, equal, mismatch_mask, first_valid, first_vec, mism_count} !== '0) begin
      errors++;
      $display("FAIL abort_clear: got busy=%b done=%b eq=%b mask=%b fv=%b first=%0d cnt=%0d, need all zero",
               busy, done, equal, mismatch_mask, first_valid, first_vec, mism_count);
    end
    done_seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL abort_stays_idle: got %0d active cycles, need 0", done_seen);
    end
    a = rnd48(); b = a ^ (rnd48() & rnd48());
    e = model(a, b);
    do_sweep(a, b, o);
    checks++;
    if (o.cycles !== e.cycles || o.mask !== e.mask || o.cnt !== e.cnt || o.first !== e.first || o.eq !== e.eq) begin
      errors++;
      $display("FAIL after_abort_sweep: got cyc=%0d mask=%b cnt=%0d first=%0d eq=%b, need %0d %b %0d %0d %b",
               o.cycles, o.mask, o.cnt, o.first, o.eq, e.cycles, e.mask, e.cnt, e.first, e.eq);
    end
  endtask

  task automatic test_rst_mid();
    logic [TT_W-1:0] a;
    a = rnd48();
    @(negedge clk);
    tt_a = a; tt_b = ~a; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, equal, mismatch_mask, first_valid, first_vec, mism_count} !== '0) begin
      errors++;
      $display("FAIL rst_mid_sweep: got busy=%b done=%b eq=%b mask=%b fv=%b first=%0d cnt=%0d, need all zero",
               busy, done, equal, mismatch_mask, first_valid, first_vec, mism_count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_abort_start_idle();
    int active;
    @(negedge clk);
    tt_a = rnd48(); tt_b = rnd48(); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    active = 0;
    repeat (20) begin
      if (busy || done) active++;
      @(posedge clk); #1;
    end
    checks++;
    if (active !== 0 || mism_count !== '0) begin
      errors++;
      $display("FAIL abort_start_same_cycle: got %0d active cycles cnt=%0d, need 0 and 0", active, mism_count);
    end
  endtask

  initial begin
    test_reset();
    test_sweep_patterns();
    test_hold();
    test_abort();
    test_rst_mid();
    test_abort_start_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
